// File: rtl/adc_capture_core_pkg.sv
// rtl/adc_capture_core_pkg.sv - shared constants and types for the ADC capture engine
package rfsoc_config;

    localparam int config_reg_width = 16;

    typedef logic [1:0] state_t;
    localparam state_t STATE_IDLE    = 2'd0;
    localparam state_t STATE_CAPTURE = 2'd1;
    localparam state_t STATE_READOUT = 2'd2;

    // Bit positions of the config/trigger lines on the legacy GPIO bank
    typedef enum int {
        GPIO_SDATA                   = 0,
        GPIO_TRIGGER_LINE            = 1,
        GPIO_ADC_NUM_CYCLE_COUNT_CLK = 2,
        GPIO_ADC_SHIFT_VAL_CLK       = 3,
        GPIO_ADC_MODE_CLK            = 4
    } gpio_bit_e;

    // Mode register layout: channel select in the low byte, decimation enable above it
    localparam int MODE_CH_LSB    = 0;
    localparam int MODE_CH_W      = 8;
    localparam int MODE_DECIM_BIT = 8;

endpackage

// File: rtl/adc_cfg_shift_reg.sv
// rtl/adc_cfg_shift_reg.sv - strobe edge detect plus LSB-first serial config register
module adc_cfg_shift_reg #(
    parameter int CFG_W = 16
) (
    input  logic             pl_clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic             sdata,
    input  logic             enable,
    output logic [CFG_W-1:0] value
);

    logic             strobe_q, strobe_d;
    logic [CFG_W-1:0] value_q, value_d;

    // Shift the new bit in at the top so the first bit sent ends up in bit 0
    always_comb begin
        strobe_d = strobe;
        value_d  = value_q;
        if (strobe && !strobe_q && enable) begin
            value_d = {sdata, value_q[CFG_W-1:1]};
        end
    end

    // Strobe history and register contents
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            value_q  <= '0;
        end else begin
            strobe_q <= strobe_d;
            value_q  <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/adc_capture_core.sv
// rtl/adc_capture_core.sv - triggered ADC burst capture with buffered width-converted readout
module adc_capture_core
    import rfsoc_config::*;
#(
    parameter int SAMPLE_W         = 16,
    parameter int SAMPLES_PER_BEAT = 8,
    parameter int NUM_CH           = 2,
    parameter int DEPTH            = 1024,
    parameter int OUT_W            = 32,
    parameter int CFG_W            = config_reg_width
) (
    input  logic                                  pl_clk,
    input  logic                                  rst,
    input  logic                                  cfg_sdata,
    input  logic                                  cfg_cycles_clk,
    input  logic                                  cfg_shift_clk,
    input  logic                                  cfg_mode_clk,
    input  logic                                  cfg_select,
    input  logic                                  trigger,
    input  logic [NUM_CH*SAMPLES_PER_BEAT*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                                  s_axis_tvalid,
    output logic                                  s_axis_tready,
    output logic [OUT_W-1:0]                      m_axis_tdata,
    output logic                                  m_axis_tvalid,
    input  logic                                  m_axis_tready,
    output logic                                  m_axis_tlast,
    output logic                                  busy,
    output logic                                  overflow
);

    localparam int BEAT_W = SAMPLES_PER_BEAT * SAMPLE_W;
    localparam int WPB    = BEAT_W / OUT_W;
    localparam int AW     = $clog2(DEPTH);
    localparam int CNT_W  = AW + 1;
    localparam int WI_W   = (WPB > 1) ? $clog2(WPB) : 1;
    localparam int SH_W   = (SAMPLE_W > 2) ? $clog2(SAMPLE_W) : 1;

    localparam logic [CFG_W:0]   DEPTH_EXT  = (CFG_W + 1)'(DEPTH);
    localparam logic [CFG_W-1:0] SHIFT_MAX  = CFG_W'(SAMPLE_W - 1);
    localparam logic [7:0]       NUM_CH_B   = 8'(NUM_CH);
    localparam logic [WI_W-1:0]  LAST_WORD  = WI_W'(WPB - 1);

    logic [CFG_W-1:0] cycles_val, shift_val, mode_val;
    logic             cfg_en;
    logic             cfg_unused;

    logic [CNT_W-1:0] len_eff;
    logic [SH_W-1:0]  sh_eff;
    logic [7:0]       ch_eff;

    state_t           state_q, state_d;
    logic             trig_q, trig_d;
    logic             tready_q, tready_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [SH_W-1:0]  sh_q, sh_d;
    logic [7:0]       ch_q, ch_d;
    logic             decim_q, decim_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic             rd_ok_q, rd_ok_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [WI_W-1:0]  word_idx_q, word_idx_d;
    logic             tvalid_q, tvalid_d;
    logic             overflow_q, overflow_d;

    logic              trig_edge, take, beat_done, last_word, wr_en;
    logic [BEAT_W-1:0] beat_sel, wr_data, rd_data_q;
    logic [BEAT_W-1:0] mem [DEPTH];

    assign cfg_en = cfg_select && (state_q == STATE_IDLE);

    adc_cfg_shift_reg #(.CFG_W(CFG_W)) u_cycles_reg (
        .pl_clk (pl_clk), .rst (rst), .strobe (cfg_cycles_clk),
        .sdata (cfg_sdata), .enable (cfg_en), .value (cycles_val)
    );

    adc_cfg_shift_reg #(.CFG_W(CFG_W)) u_shift_reg (
        .pl_clk (pl_clk), .rst (rst), .strobe (cfg_shift_clk),
        .sdata (cfg_sdata), .enable (cfg_en), .value (shift_val)
    );

    adc_cfg_shift_reg #(.CFG_W(CFG_W)) u_mode_reg (
        .pl_clk (pl_clk), .rst (rst), .strobe (cfg_mode_clk),
        .sdata (cfg_sdata), .enable (cfg_en), .value (mode_val)
    );

    // Upper mode bits are reserved
    assign cfg_unused = &{1'b0, mode_val[CFG_W-1:MODE_DECIM_BIT+1]};

    // Clamp the raw config values into the ranges the datapath can honour
    always_comb begin
        len_eff = ({1'b0, cycles_val} > DEPTH_EXT) ? CNT_W'(DEPTH) : CNT_W'(cycles_val);
        sh_eff  = (shift_val > SHIFT_MAX) ? SH_W'(SAMPLE_W - 1) : SH_W'(shift_val);
        ch_eff  = (mode_val[MODE_CH_LSB +: MODE_CH_W] >= NUM_CH_B) ? 8'd0
                                                                  : mode_val[MODE_CH_LSB +: MODE_CH_W];
    end

    // Pick the latched channel and sign-extend/shift every sample of the beat
    always_comb begin
        beat_sel = '0;
        wr_data  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_q == 8'(c)) begin
                beat_sel = s_axis_tdata[c*BEAT_W +: BEAT_W];
            end
        end
        for (int i = 0; i < SAMPLES_PER_BEAT; i++) begin
            wr_data[i*SAMPLE_W +: SAMPLE_W] =
                SAMPLE_W'($signed(beat_sel[i*SAMPLE_W +: SAMPLE_W]) >>> sh_q);
        end
    end

    assign trig_edge = trigger && !trig_q;
    assign take      = tvalid_q && m_axis_tready;
    assign last_word = (word_idx_q == LAST_WORD);
    assign beat_done = take && last_word;

    // Capture/readout sequencing; the readout register reloads from the prefetched RAM word
    always_comb begin
        state_d    = state_q;
        trig_d     = trigger;
        tready_d   = 1'b1;
        len_d      = len_q;
        sh_d       = sh_q;
        ch_d       = ch_q;
        decim_d    = decim_q;
        phase_d    = phase_q;
        wr_cnt_d   = wr_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        rd_ok_d    = (state_q == STATE_READOUT);
        beat_cnt_d = beat_cnt_q;
        beat_d     = beat_q;
        word_idx_d = word_idx_q;
        tvalid_d   = tvalid_q;
        overflow_d = overflow_q;
        wr_en      = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (trig_edge && (len_eff != '0)) begin
                    state_d    = STATE_CAPTURE;
                    len_d      = len_eff;
                    sh_d       = sh_eff;
                    ch_d       = ch_eff;
                    decim_d    = mode_val[MODE_DECIM_BIT];
                    phase_d    = 1'b0;
                    wr_cnt_d   = '0;
                    rd_ptr_d   = '0;
                    beat_cnt_d = '0;
                    word_idx_d = '0;
                    overflow_d = 1'b0;
                end
            end
            STATE_CAPTURE: begin
                if (trig_edge) begin
                    overflow_d = 1'b1;
                end
                if (s_axis_tvalid) begin
                    phase_d = !phase_q;
                    if (!decim_q || !phase_q) begin
                        wr_en    = 1'b1;
                        wr_cnt_d = wr_cnt_q + CNT_W'(1);
                        if (wr_cnt_d == len_q) begin
                            state_d = STATE_READOUT;
                        end
                    end
                end
            end
            STATE_READOUT: begin
                if (trig_edge) begin
                    overflow_d = 1'b1;
                end
                if (take && !last_word) begin
                    beat_d     = beat_q >> OUT_W;
                    word_idx_d = word_idx_q + WI_W'(1);
                end
                if (take && m_axis_tlast) begin
                    tvalid_d = 1'b0;
                    state_d  = STATE_IDLE;
                end else if (rd_ok_q && (beat_cnt_q != len_q) && (!tvalid_q || beat_done)) begin
                    beat_d     = rd_data_q;
                    word_idx_d = '0;
                    tvalid_d   = 1'b1;
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                end
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge pl_clk or posedge rst) begin
        if (rst) begin
            state_q    <= STATE_IDLE;
            trig_q     <= 1'b0;
            tready_q   <= 1'b0;
            len_q      <= '0;
            sh_q       <= '0;
            ch_q       <= '0;
            decim_q    <= 1'b0;
            phase_q    <= 1'b0;
            wr_cnt_q   <= '0;
            rd_ptr_q   <= '0;
            rd_ok_q    <= 1'b0;
            beat_cnt_q <= '0;
            beat_q     <= '0;
            word_idx_q <= '0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trig_d;
            tready_q   <= tready_d;
            len_q      <= len_d;
            sh_q       <= sh_d;
            ch_q       <= ch_d;
            decim_q    <= decim_d;
            phase_q    <= phase_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_ok_q    <= rd_ok_d;
            beat_cnt_q <= beat_cnt_d;
            beat_q     <= beat_d;
            word_idx_q <= word_idx_d;
            tvalid_q   <= tvalid_d;
            overflow_q <= overflow_d;
        end
    end

    // Burst buffer: read address follows the next pointer so rd_data_q always holds mem[rd_ptr_q]
    always_ff @(posedge pl_clk) begin
        if (wr_en) begin
            mem[wr_cnt_q[AW-1:0]] <= wr_data;
        end
        rd_data_q <= mem[rd_ptr_d];
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = beat_q[OUT_W-1:0];
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tvalid_q && last_word && (beat_cnt_q == len_q);
    assign busy          = (state_q != STATE_IDLE);
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_adc_capture_core.sv
// tb/tb_adc_capture_core.sv - directed self-checking bench for adc_capture_core
module tb_adc_capture_core;

    localparam int SAMPLE_W = 16;
    localparam int SPB      = 8;
    localparam int NUM_CH   = 2;
    localparam int DEPTH    = 16;
    localparam int OUT_W    = 32;
    localparam int CFG_W    = 16;
    localparam int BEAT_W   = SPB * SAMPLE_W;
    localparam int IN_W     = NUM_CH * BEAT_W;

    logic              pl_clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_sdata = 1'b0;
    logic              cfg_cycles_clk = 1'b0;
    logic              cfg_shift_clk = 1'b0;
    logic              cfg_mode_clk = 1'b0;
    logic              cfg_select = 1'b0;
    logic              trigger = 1'b0;
    logic [IN_W-1:0]   s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic [OUT_W-1:0]  m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b0;
    logic              m_axis_tlast;
    logic              busy;
    logic              overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [31:0] got[$];
    int          got_last[$];
    int          first_valid;
    int          stable_err;
    bit          burst_done;

    adc_capture_core #(
        .SAMPLE_W(SAMPLE_W), .SAMPLES_PER_BEAT(SPB), .NUM_CH(NUM_CH),
        .DEPTH(DEPTH), .OUT_W(OUT_W), .CFG_W(CFG_W)
    ) dut (
        .pl_clk(pl_clk), .rst(rst), .cfg_sdata(cfg_sdata),
        .cfg_cycles_clk(cfg_cycles_clk), .cfg_shift_clk(cfg_shift_clk),
        .cfg_mode_clk(cfg_mode_clk), .cfg_select(cfg_select), .trigger(trigger),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast), .busy(busy), .overflow(overflow)
    );

    always #5 pl_clk = ~pl_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ch0 lanes 8,7,...,1 (lane0 = 8); ch1 filler
    function automatic logic [IN_W-1:0] basic_beat();
        logic [IN_W-1:0] b;
        for (int j = 0; j < SPB; j++) begin
            b[j*SAMPLE_W +: SAMPLE_W]          = 16'(8 - j);
            b[BEAT_W + j*SAMPLE_W +: SAMPLE_W] = 16'hDEAD;
        end
        return b;
    endfunction

    function automatic logic [31:0] basic_word(input int w);
        return {16'(8 - (2*w + 1)), 16'(8 - 2*w)};
    endfunction

    // ch1 lane j of beat k = k + 0x100*j; ch0 filler
    function automatic logic [IN_W-1:0] idx_beat(input int k);
        logic [IN_W-1:0] b;
        for (int j = 0; j < SPB; j++) begin
            b[j*SAMPLE_W +: SAMPLE_W]          = 16'hFFFF;
            b[BEAT_W + j*SAMPLE_W +: SAMPLE_W] = 16'(k + 256*j);
        end
        return b;
    endfunction

    function automatic logic [31:0] idx_word(input int k, input int w);
        return {16'(k + 256*(2*w + 1)), 16'(k + 256*2*w)};
    endfunction

    // sel bit0 = cycles, bit1 = shift, bit2 = mode
    task automatic cfg_write(input logic [2:0] sel, input logic [15:0] val);
        cfg_select = 1'b1;
        for (int i = 0; i < CFG_W; i++) begin
            cfg_sdata      = val[i];
            cfg_cycles_clk = sel[0];
            cfg_shift_clk  = sel[1];
            cfg_mode_clk   = sel[2];
            @(negedge pl_clk);
            cfg_cycles_clk = 1'b0;
            cfg_shift_clk  = 1'b0;
            cfg_mode_clk   = 1'b0;
            @(negedge pl_clk);
        end
        cfg_select = 1'b0;
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(negedge pl_clk);
        trigger = 1'b0;
    endtask

    task automatic collect(input bit rnd, input int exp_first);
        logic [31:0] held;
        bit          holding;
        got.delete();
        got_last.delete();
        first_valid = -1;
        stable_err  = 0;
        burst_done  = 0;
        holding     = 0;
        held        = '0;
        for (int cyc = 0; cyc < 3000 && !burst_done; cyc++) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_axis_tvalid) begin
                if (first_valid < 0) first_valid = cyc;
                if (holding && (m_axis_tdata !== held)) stable_err++;
                if (m_axis_tready) begin
                    got.push_back(m_axis_tdata);
                    got_last.push_back(int'(m_axis_tlast));
                    holding = 0;
                    if (m_axis_tlast) burst_done = 1;
                end else begin
                    holding = 1;
                    held    = m_axis_tdata;
                end
            end
            @(negedge pl_clk);
        end
        m_axis_tready = 1'b0;
        check("burst_done", 64'(burst_done), 64'd1);
        if (exp_first >= 0) check("first_valid_latency", 64'(first_valid), 64'(exp_first));
        check("tdata_stable", 64'(stable_err), 64'd0);
        check("tvalid_after_last", 64'(m_axis_tvalid), 64'd0);
        check("busy_after_last", 64'(busy), 64'd0);
    endtask

    task automatic check_basic_burst(input string tag);
        int nerr;
        nerr = 0;
        check({tag, "_count"}, 64'(got.size()), 64'd16);
        for (int i = 0; i < 16; i++) begin
            if (got[i] !== basic_word(i % 4)) nerr++;
            if (got_last[i] != int'(i == 15)) nerr++;
        end
        check({tag, "_words_and_last"}, 64'(nerr), 64'd0);
        check({tag, "_word0"}, 64'(got[0]), 64'h0007_0008);
    endtask

    task automatic check_decim_burst(input string tag);
        int nerr;
        nerr = 0;
        check({tag, "_count"}, 64'(got.size()), 64'd12);
        for (int i = 0; i < 12; i++) begin
            if (got[i] !== idx_word(2 * (i / 4), i % 4)) nerr++;
            if (got_last[i] != int'(i == 11)) nerr++;
        end
        check({tag, "_words_and_last"}, 64'(nerr), 64'd0);
        check({tag, "_beat2_low"}, 64'(got[8][15:0]), 64'h0004);
    endtask

    task automatic drive_idx_beats(input int n);
        for (int k = 0; k < n; k++) begin
            s_axis_tdata  = idx_beat(k);
            s_axis_tvalid = 1'b1;
            @(negedge pl_clk);
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        int nerr;
        logic [IN_W-1:0] b;

        // Reset state
        repeat (3) @(negedge pl_clk);
        check("rst_tready", 64'(s_axis_tready), 64'd0);
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        rst = 1'b0;
        @(negedge pl_clk);
        check("tready_after_rst", 64'(s_axis_tready), 64'd1);

        // cycles=0: trigger ignored
        pulse_trigger();
        check("len0_idle_a", 64'(busy), 64'd0);
        @(negedge pl_clk);
        check("len0_idle_b", 64'(busy), 64'd0);

        // Basic burst on channel 0
        cfg_write(3'b001, 16'd4);
        cfg_write(3'b110, 16'd0);
        s_axis_tdata  = basic_beat();
        s_axis_tvalid = 1'b1;
        pulse_trigger();
        check("basic_busy", 64'(busy), 64'd1);
        collect(1'b0, 6);
        check_basic_burst("basic");

        // Shift 2 with sign extension
        cfg_write(3'b001, 16'd1);
        cfg_write(3'b010, 16'd2);
        b = '0;
        b[15:0]  = 16'h8000;
        b[31:16] = 16'h0010;
        b[BEAT_W +: 16] = 16'h1234;
        s_axis_tdata = b;
        pulse_trigger();
        collect(1'b0, -1);
        check("shift2_count", 64'(got.size()), 64'd4);
        check("shift2_word0", 64'(got[0]), 64'h0004_E000);

        // shift=20 clamps to 15; mode=20 is out of range and falls back to channel 0
        cfg_write(3'b110, 16'd20);
        pulse_trigger();
        collect(1'b0, -1);
        check("shift20_word0", 64'(got[0]), 64'h0000_FFFF);

        // Channel 1 with decimation, overflow and ignored config while busy
        cfg_write(3'b001, 16'd3);
        cfg_write(3'b010, 16'd0);
        cfg_write(3'b100, 16'h0101);
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;
        pulse_trigger();
        drive_idx_beats(10);
        check("decim_in_readout_busy", 64'(busy), 64'd1);
        pulse_trigger();
        @(negedge pl_clk);
        check("overflow_set", 64'(overflow), 64'd1);
        cfg_select = 1'b1;
        cfg_sdata  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_cycles_clk = 1'b1; cfg_shift_clk = 1'b1; cfg_mode_clk = 1'b1;
            @(negedge pl_clk);
            cfg_cycles_clk = 1'b0; cfg_shift_clk = 1'b0; cfg_mode_clk = 1'b0;
            @(negedge pl_clk);
        end
        cfg_select = 1'b0;
        collect(1'b0, -1);
        check_decim_burst("decim");
        check("overflow_sticky", 64'(overflow), 64'd1);

        // Same burst again without reprogramming: registers untouched, overflow cleared
        pulse_trigger();
        check("overflow_cleared", 64'(overflow), 64'd0);
        drive_idx_beats(10);
        collect(1'b0, -1);
        check_decim_burst("decim_again");

        // Random backpressure, channel 1 without decimation
        cfg_write(3'b001, 16'd4);
        cfg_write(3'b100, 16'h0001);
        pulse_trigger();
        drive_idx_beats(6);
        collect(1'b1, -1);
        check("bp_count", 64'(got.size()), 64'd16);
        nerr = 0;
        for (int i = 0; i < 16; i++) begin
            if (got[i] !== idx_word(i / 4, i % 4)) nerr++;
        end
        check("bp_words", 64'(nerr), 64'd0);

        // cycles beyond DEPTH clamps to DEPTH beats
        cfg_write(3'b001, 16'(DEPTH + 5));
        cfg_write(3'b100, 16'h0000);
        s_axis_tdata  = basic_beat();
        s_axis_tvalid = 1'b1;
        pulse_trigger();
        collect(1'b0, -1);
        check("depth_count", 64'(got.size()), 64'(DEPTH * 4));
        nerr = 0;
        for (int i = 0; i < DEPTH * 4; i++) begin
            if (got[i] !== basic_word(i % 4)) nerr++;
            if (got_last[i] != int'(i == DEPTH * 4 - 1)) nerr++;
        end
        check("depth_words_and_last", 64'(nerr), 64'd0);

        // Reset in the middle of a capture
        cfg_write(3'b001, 16'd4);
        s_axis_tvalid = 1'b0;
        pulse_trigger();
        s_axis_tvalid = 1'b1;
        repeat (2) @(negedge pl_clk);
        s_axis_tvalid = 1'b0;
        pulse_trigger();
        check("midcap_overflow", 64'(overflow), 64'd1);
        check("midcap_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_overflow", 64'(overflow), 64'd0);
        check("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("async_rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("async_rst_tready", 64'(s_axis_tready), 64'd0);
        @(negedge pl_clk);
        rst = 1'b0;
        @(negedge pl_clk);
        pulse_trigger();
        @(negedge pl_clk);
        check("cycles_zero_after_rst", 64'(busy), 64'd0);
        cfg_write(3'b001, 16'd4);
        s_axis_tvalid = 1'b1;
        pulse_trigger();
        collect(1'b0, 6);
        check_basic_burst("after_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
